// File: rtl/view_pkg.sv
// view_pkg: shared FSM state, command struct, default view and scaler constants for view_update_sequencer
package view_pkg;
  typedef enum logic [2:0] {IDLE, MUL_W, MUL_H, MUL_WAIT, ADD_X, ADD_Y, ADD_WAIT, COMMIT} state_e;
  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic zoom_in;
    logic zoom_out;
  } cmd_t;
  localparam logic [63:0] DEF_X = 64'h0000000000000000;
  localparam logic [63:0] DEF_Y = 64'h0000000000000000;
  localparam logic [63:0] DEF_WIDTH = 64'h4000000000000000;
  localparam logic [63:0] DEF_HEIGHT = 64'h3FF8000000000000;
  localparam logic [63:0] SCALE_IN = 64'h3FEFEB851EB851EC;
  localparam logic [63:0] SCALE_OUT = 64'h3FF00A440290B773;
  localparam logic [63:0] SCALE_ONE = 64'h3FF0000000000000;
  localparam logic [10:0] DIV64_EXP_SHIFT = 11'd6;
  function automatic cmd_t resolve(input cmd_t c, input logic at_floor);
    resolve = c;
    resolve.up = c.up & ~c.down;
    resolve.down = c.down & ~c.up;
    resolve.left = c.left & ~c.right;
    resolve.right = c.right & ~c.left;
    resolve.zoom_in = c.zoom_in & ~c.zoom_out & ~at_floor;
    resolve.zoom_out = c.zoom_out & ~c.zoom_in;
  endfunction
endpackage

// File: rtl/view_delta_gen.sv
// view_delta_gen: dim/64 as a double (exponent-6, flush to +0 when exponent<=6), sign flipped by neg, +0 when en is low
module view_delta_gen import view_pkg::*; (
  input  logic [63:0] dim,
  input  logic        neg,
  input  logic        en,
  output logic [63:0] delta
);
  logic [10:0] e;
  always_comb begin
    e = dim[62:52];
    delta = (!en || e <= DIV64_EXP_SHIFT) ? 64'd0 : {dim[63] ^ neg, e - DIV64_EXP_SHIFT, dim[51:0]};
  end
endmodule

// File: rtl/view_update_sequencer.sv
// view_update_sequencer: tick-driven pan/zoom over a shared pipelined mul/add; ports clock/reset, tick, commands, renderer_idle, datapath operands/results, committed view, view_updated, busy; VIEW_SEQ_DROP_COUNT_EN adds dropped_ticks
module view_update_sequencer import view_pkg::*; #(
  parameter int          MUL_LATENCY   = 5,
  parameter int          ADD_LATENCY   = 7,
  parameter logic [10:0] MIN_WIDTH_EXP = 11'd970
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        pan_up,
  input  logic        pan_down,
  input  logic        pan_left,
  input  logic        pan_right,
  input  logic        zoom_in,
  input  logic        zoom_out,
  input  logic        renderer_idle,
  input  logic [63:0] mul_result,
  input  logic [63:0] add_result,
  output logic [63:0] mul_a,
  output logic [63:0] mul_b,
  output logic [63:0] add_a,
  output logic [63:0] add_b,
  output logic [63:0] x_center,
  output logic [63:0] y_center,
  output logic [63:0] width,
  output logic [63:0] height,
  output logic        view_updated,
  output logic        busy
`ifdef VIEW_SEQ_DROP_COUNT_EN
  ,
  output logic [15:0] dropped_ticks
`endif
);
  state_e state_q, state_d;
  cmd_t cmd_q, cmd_d, res, raw;
  logic pend_q, pend_d, upd_q, upd_d;
  logic [63:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [63:0] nx_q, nx_d, ny_q, ny_d, nw_q, nw_d, nh_q, nh_d;
  logic [63:0] scaler, dx, dy;
  logic [MUL_LATENCY-1:0] mvw_q, mvw_d, mvh_q, mvh_d;
  logic [ADD_LATENCY-1:0] avx_q, avx_d, avy_q, avy_d;
  view_delta_gen u_dx (.dim(nw_q), .neg(cmd_q.left), .en(cmd_q.left | cmd_q.right), .delta(dx));
  view_delta_gen u_dy (.dim(nh_q), .neg(cmd_q.up), .en(cmd_q.up | cmd_q.down), .delta(dy));
  assign raw = {pan_up, pan_down, pan_left, pan_right, zoom_in, zoom_out};
  assign busy = state_q != IDLE;
  assign view_updated = upd_q;
  assign x_center = x_q;
  assign y_center = y_q;
  assign width = w_q;
  assign height = h_q;
  // A tick only latches the raw command; it is resolved one cycle later in IDLE
  // against the committed width, and an empty result never leaves IDLE.
  always_comb begin
    res = resolve(cmd_q, w_q[62:52] <= MIN_WIDTH_EXP);
    scaler = cmd_q.zoom_in ? SCALE_IN : cmd_q.zoom_out ? SCALE_OUT : SCALE_ONE;
    mul_a = state_q == MUL_W ? w_q : state_q == MUL_H ? h_q : 64'd0;
    mul_b = (state_q == MUL_W || state_q == MUL_H) ? scaler : 64'd0;
    add_a = state_q == ADD_X ? x_q : state_q == ADD_Y ? y_q : 64'd0;
    add_b = state_q == ADD_X ? dx : state_q == ADD_Y ? dy : 64'd0;
    mvw_d = (mvw_q << 1) | MUL_LATENCY'(state_q == MUL_W);
    mvh_d = (mvh_q << 1) | MUL_LATENCY'(state_q == MUL_H);
    avx_d = (avx_q << 1) | ADD_LATENCY'(state_q == ADD_X);
    avy_d = (avy_q << 1) | ADD_LATENCY'(state_q == ADD_Y);
    nw_d = mvw_q[MUL_LATENCY-1] ? mul_result : nw_q;
    nh_d = mvh_q[MUL_LATENCY-1] ? mul_result : nh_q;
    nx_d = avx_q[ADD_LATENCY-1] ? add_result : nx_q;
    ny_d = avy_q[ADD_LATENCY-1] ? add_result : ny_q;
    state_d = state_q;
    cmd_d = cmd_q;
    pend_d = pend_q;
    upd_d = 1'b0;
    x_d = x_q;
    y_d = y_q;
    w_d = w_q;
    h_d = h_q;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          pend_d = 1'b0;
          cmd_d = res;
          state_d = res != '0 ? MUL_W : IDLE;
        end else if (tick) begin
          pend_d = 1'b1;
          cmd_d = raw;
        end
      end
      MUL_W: state_d = MUL_H;
      MUL_H: state_d = MUL_WAIT;
      MUL_WAIT: state_d = mvh_q[MUL_LATENCY-1] ? ADD_X : MUL_WAIT;
      ADD_X: state_d = ADD_Y;
      ADD_Y: state_d = ADD_WAIT;
      ADD_WAIT: state_d = avy_q[ADD_LATENCY-1] ? COMMIT : ADD_WAIT;
      COMMIT: begin
        if (renderer_idle) begin
          x_d = nx_q;
          y_d = ny_q;
          w_d = nw_q;
          h_d = nh_q;
          upd_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
      pend_q <= 1'b0;
      upd_q <= 1'b0;
      x_q <= DEF_X;
      y_q <= DEF_Y;
      w_q <= DEF_WIDTH;
      h_q <= DEF_HEIGHT;
      nx_q <= 64'd0;
      ny_q <= 64'd0;
      nw_q <= 64'd0;
      nh_q <= 64'd0;
      mvw_q <= '0;
      mvh_q <= '0;
      avx_q <= '0;
      avy_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
      pend_q <= pend_d;
      upd_q <= upd_d;
      x_q <= x_d;
      y_q <= y_d;
      w_q <= w_d;
      h_q <= h_d;
      nx_q <= nx_d;
      ny_q <= ny_d;
      nw_q <= nw_d;
      nh_q <= nh_d;
      mvw_q <= mvw_d;
      mvh_q <= mvh_d;
      avx_q <= avx_d;
      avy_q <= avy_d;
    end
  end
`ifdef VIEW_SEQ_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;
  assign drop_d = (tick && busy && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  assign dropped_ticks = drop_q;
  always_ff @(posedge clock) begin
    if (reset) drop_q <= 16'd0;
    else drop_q <= drop_d;
  end
`endif
endmodule

// File: tb/tb_view_update_sequencer.sv
// tb_view_update_sequencer: real-valued mul/add pipelines plus a real-arithmetic view model checking view_update_sequencer
module tb_view_update_sequencer;
  localparam int ML = 5;
  localparam int AL = 7;
  localparam int LAT = 6 + ML + AL;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic pan_up = 1'b0, pan_down = 1'b0, pan_left = 1'b0, pan_right = 1'b0;
  logic zoom_in = 1'b0, zoom_out = 1'b0;
  logic renderer_idle = 1'b1;
  logic [63:0] mul_a, mul_b, add_a, add_b, mul_result, add_result;
  logic [63:0] x_center, y_center, width, height;
  logic view_updated, busy;
`ifdef VIEW_SEQ_DROP_COUNT_EN
  logic [15:0] dropped_ticks;
`endif
  int vectors = 0;
  int miscompares = 0;
  real mp [ML];
  real ap [AL];
  real mx, my, mw, mh, ex, ey, ew, eh;

  view_update_sequencer #(.MUL_LATENCY(ML), .ADD_LATENCY(AL), .MIN_WIDTH_EXP(11'd970)) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .pan_up(pan_up), .pan_down(pan_down), .pan_left(pan_left), .pan_right(pan_right),
    .zoom_in(zoom_in), .zoom_out(zoom_out), .renderer_idle(renderer_idle),
    .mul_a(mul_a), .mul_b(mul_b), .add_a(add_a), .add_b(add_b),
    .mul_result(mul_result), .add_result(add_result),
    .x_center(x_center), .y_center(y_center), .width(width), .height(height),
    .view_updated(view_updated), .busy(busy)
`ifdef VIEW_SEQ_DROP_COUNT_EN
    , .dropped_ticks(dropped_ticks)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    mp[0] <= $bitstoreal(mul_a) * $bitstoreal(mul_b);
    for (int i = 1; i < ML; i++) mp[i] <= mp[i-1];
    ap[0] <= $bitstoreal(add_a) + $bitstoreal(add_b);
    for (int i = 1; i < AL; i++) ap[i] <= ap[i-1];
  end
  assign mul_result = $realtobits(mp[ML-1]);
  assign add_result = $realtobits(ap[AL-1]);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_view(input string tag);
    chk({tag, ".x"}, x_center, $realtobits(mx));
    chk({tag, ".y"}, y_center, $realtobits(my));
    chk({tag, ".w"}, width, $realtobits(mw));
    chk({tag, ".h"}, height, $realtobits(mh));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    mx = 0.0; my = 0.0; mw = 2.0; mh = 1.5;
  endtask

  // c = {up, down, left, right, zoom_in, zoom_out}
  task automatic model_next(input logic [5:0] c, output bit active);
    bit u, d, l, r, zi, zo, pu, pd, pl, pr;
    real s;
    {u, d, l, r, zi, zo} = c;
    pu = u && !d; pd = d && !u; pl = l && !r; pr = r && !l;
    if (zi && zo) begin zi = 0; zo = 0; end
    if (zi && mw < $bitstoreal(64'h3CB0000000000000)) zi = 0;
    active = zi || zo || pu || pd || pl || pr;
    s = zi ? $bitstoreal(64'h3FEFEB851EB851EC) : zo ? $bitstoreal(64'h3FF00A440290B773) : 1.0;
    ew = mw * s;
    eh = mh * s;
    ex = mx + (pr ? ew / 64.0 : pl ? -ew / 64.0 : 0.0);
    ey = my + (pd ? eh / 64.0 : pu ? -eh / 64.0 : 0.0);
  endtask

  task automatic commit_model();
    mx = ex; my = ey; mw = ew; mh = eh;
  endtask

  task automatic issue(input logic [5:0] c);
    {pan_up, pan_down, pan_left, pan_right, zoom_in, zoom_out} = c;
    tick = 1'b1;
    @(posedge clock);
    #1 tick = 1'b0;
    {pan_up, pan_down, pan_left, pan_right, zoom_in, zoom_out} = 6'($urandom);
  endtask

  task automatic wait_pulse(input bit rnd, output int n);
    n = 0;
    while (n < 400) begin
      @(posedge clock);
      #1 n++;
      if (view_updated) break;
      if (rnd) renderer_idle = 1'($urandom_range(0, 1));
    end
    renderer_idle = 1'b1;
  endtask

  task automatic quiet(input string tag, input int cycles);
    bit saw = 0;
    repeat (cycles) begin
      @(posedge clock);
      #1 saw |= view_updated;
    end
    chk(tag, {63'd0, saw}, 64'd0);
  endtask

  task automatic run(input string tag, input logic [5:0] c, input bit rnd, input int want);
    bit act;
    int n;
    bit saw;
    model_next(c, act);
    issue(c);
    if (act) begin
      wait_pulse(rnd, n);
      chk({tag, ".pulse"}, {63'd0, view_updated}, 64'd1);
      if (want > 0) chk({tag, ".latency"}, 64'(n), 64'(want));
      commit_model();
      check_view(tag);
      @(posedge clock);
      #1 chk({tag, ".pulse_width"}, {63'd0, view_updated}, 64'd0);
    end else begin
      saw = 0;
      repeat (24) begin
        @(posedge clock);
        #1 saw |= view_updated | busy;
      end
      chk({tag, ".empty"}, {63'd0, saw}, 64'd0);
      check_view(tag);
    end
  endtask

  initial begin
    int n;
    bit saw;
    bit act;
    do_reset();
    check_view("reset");
    chk("reset.upd", {63'd0, view_updated}, 64'd0);
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.mul_a", mul_a, 64'd0);
    run("pan_right", 6'b000100, 0, LAT);
    chk("pan_right.x_const", x_center, 64'h3FA0000000000000);
    do_reset();
    run("zoomin_down", 6'b010010, 0, LAT);
    run("all_conflict", 6'b001111, 0, 0);
    run("updown_conflict", 6'b110000, 0, 0);
    // Renderer busy: sequence parks in COMMIT, commits on the first idle edge
    renderer_idle = 1'b0;
    model_next(6'b100001, act);
    issue(6'b100001);
    saw = 0;
    repeat (50) begin
      @(posedge clock);
      #1 saw |= view_updated;
    end
    chk("hold.busy", {63'd0, busy}, 64'd1);
    chk("hold.no_pulse", {63'd0, saw}, 64'd0);
    check_view("hold.unchanged");
    renderer_idle = 1'b1;
    wait_pulse(0, n);
    chk("hold.latency", 64'(n), 64'd1);
    commit_model();
    check_view("hold.commit");
    // Second tick while busy is dropped
    do_reset();
    model_next(6'b000110, act);
    issue(6'b000110);
    @(posedge clock);
    @(posedge clock);
    #1 {pan_up, pan_down, pan_left, pan_right, zoom_in, zoom_out} = 6'b101010;
    tick = 1'b1;
    @(posedge clock);
    #1 tick = 1'b0;
    wait_pulse(0, n);
    chk("drop.latency", 64'(n), 64'(LAT - 3));
    commit_model();
    check_view("drop");
    quiet("drop.single", 30);
`ifdef VIEW_SEQ_DROP_COUNT_EN
    chk("drop.count", {48'd0, dropped_ticks}, 64'd1);
`endif
    // Reset in MUL_WAIT discards the in-flight sequence
    model_next(6'b011001, act);
    issue(6'b011001);
    repeat (3) @(posedge clock);
    #1 chk("midreset.busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    mx = 0.0; my = 0.0; mw = 2.0; mh = 1.5;
    check_view("midreset");
    chk("midreset.busy", {63'd0, busy}, 64'd0);
    chk("midreset.upd", {63'd0, view_updated}, 64'd0);
    quiet("midreset.no_pulse", 30);
    check_view("midreset.after");
    run("after_reset", 6'b001001, 0, LAT);
    // Randomized commands with random renderer stalls
    for (int k = 0; k < 40; k++) run("random", 6'($urandom), 1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
